weight_shift_tile: RTL and testbench

Parametrised weight-holding tile for the systolic convolution array: the next generation of the fixed 16-lane, 3x3-kernel, 19x19-output weight register. On `start` it fetches one bank of CH signed kernel weights from memory, holds them, and sweeps a nested kernel/output counter (x, y, X, Y). On every active sweep cycle it raises exactly one hand-off strobe: east (x advances), south (y advances) or home (return at the right-hand edge). Adds a start/busy/finish handshake, a stall input, a selectable weight bank and generic geometry.

---
 rtl/weight_shift_tile.sv | 167 ++++++++++++++++
 tb/tb_weight_shift_tile.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_shift_tile.sv
`timescale 1ns/1ps
// Weight-holding systolic tile: fetches one bank of CH signed weights, holds them, and
// sweeps a nested x/y/X/Y counter raising exactly one east/south/home strobe per step.
module weight_shift_tile #(
    parameter int CH = 16,
    parameter int WW = 8,
    parameter int AW = 4,
    parameter int KX = 3,
    parameter int KY = 3,
    parameter int OX = 19,
    parameter int OY = 19,
    localparam int XW  = (KX > 1) ? $clog2(KX) : 1,
    localparam int YW  = (KY > 1) ? $clog2(KY) : 1,
    localparam int OXW = (OX > 1) ? $clog2(OX) : 1,
    localparam int OYW = (OY > 1) ? $clog2(OY) : 1
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic [AW-1:0]     bank,
    input  logic              stall,
    output logic              mem_re,
    output logic [AW-1:0]     mem_raddr,
    input  logic [CH*WW-1:0]  mem_rdata,
    output logic [CH*WW-1:0]  wreg,
    output logic              pass_east,
    output logic              pass_south,
    output logic              pass_home,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [OXW-1:0]    X,
    output logic [OYW-1:0]    Y,
    output logic              busy,
    output logic              finish
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [XW-1:0]  KX_MAX = XW'(KX - 1);
    localparam logic [YW-1:0]  KY_MAX = YW'(KY - 1);
    localparam logic [OXW-1:0] OX_MAX = OXW'(OX - 1);
    localparam logic [OYW-1:0] OY_MAX = OYW'(OY - 1);

    state_t             state_q;
    logic [AW-1:0]      bank_q;
    logic [CH*WW-1:0]   wreg_q;
    logic               mem_re_q;
    logic               busy_q;
    logic               finish_q;
    logic [XW-1:0]      kx_q,  kx_d;
    logic [YW-1:0]      ky_q,  ky_d;
    logic [OXW-1:0]     ox_q,  ox_d;
    logic [OYW-1:0]     oy_q,  oy_d;

    logic run_active;
    logic kx_last, ky_last, ox_last, oy_last, all_last;

    assign run_active = (state_q == S_RUN) && !stall;
    assign kx_last    = (kx_q == KX_MAX);
    assign ky_last    = (ky_q == KY_MAX);
    assign ox_last    = (ox_q == OX_MAX);
    assign oy_last    = (oy_q == OY_MAX);
    assign all_last   = kx_last && ky_last && ox_last && oy_last;

    // Home wins at the right-hand edge; otherwise a wrapping x goes south, else east.
    assign pass_home  = run_active && kx_last && ox_last;
    assign pass_south = run_active && kx_last && !ox_last;
    assign pass_east  = run_active && !kx_last;

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        if ((state_q == S_LOAD) || (run_active && all_last)) begin
            kx_d = '0;
            ky_d = '0;
            ox_d = '0;
            oy_d = '0;
        end else if (run_active) begin
            kx_d = kx_last ? '0 : kx_q + 1'b1;
            if (kx_last) begin
                ky_d = ky_last ? '0 : ky_q + 1'b1;
            end
            if (kx_last && ky_last) begin
                ox_d = ox_last ? '0 : ox_q + 1'b1;
            end
            if (kx_last && ky_last && ox_last) begin
                oy_d = oy_q + 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop sees
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q  <= S_IDLE;
            bank_q   <= '0;
            // NOTE: the wide weight register is reset too, because wreg must read 0
            // after reset and a mid-sweep reset must discard the loaded bank.
            wreg_q   <= '0;
            mem_re_q <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            kx_q     <= '0;
            ky_q     <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bank_q   <= bank;
                        mem_re_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_re_q <= 1'b0;
                    state_q  <= S_LOAD;
                end
                S_LOAD: begin
                    wreg_q  <= mem_rdata;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (run_active && all_last) begin
                        finish_q <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_re    = mem_re_q;
    assign mem_raddr = bank_q;
    assign wreg      = wreg_q;
    assign busy      = busy_q;
    assign finish    = finish_q;
    assign x         = kx_q;
    assign y         = ky_q;
    assign X         = ox_q;
    assign Y         = oy_q;

endmodule

// File: tb/tb_weight_shift_tile.sv
`timescale 1ns/1ps
// Bench for weight_shift_tile: a small 2x2/3x2 tile for directed sweeps and a
// default-geometry tile for the full-size totals; a negedge monitor scores responses.
module tb_weight_shift_tile;

    localparam int CH = 16;
    localparam int WW = 8;
    localparam int AW = 4;
    localparam int S_LAT = 27;     // 2*2*3*2 = 24 RUN cycles + 3
    localparam int D_LAT = 3252;   // 3*3*19*19 = 3249 RUN cycles + 3

    typedef struct {
        int               bank;
        int               lat;
        int               home;
        int               south;
        int               east;
        logic [CH*WW-1:0] w;
        int               t0;
    } exp_t;

    typedef struct {
        int addr;
        int t;
    } re_t;

    logic clk = 1'b0;
    logic xrst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // small geometry DUT
    logic              s_start, s_stall, s_re, s_east, s_south, s_home, s_busy, s_finish;
    logic [AW-1:0]     s_bank, s_raddr;
    logic [CH*WW-1:0]  s_rdata = '0;
    logic [CH*WW-1:0]  s_wreg;
    logic [0:0]        s_x, s_y, s_Y;
    logic [1:0]        s_X;

    // default geometry DUT
    logic              d_start, d_stall, d_re, d_east, d_south, d_home, d_busy, d_finish;
    logic [AW-1:0]     d_bank, d_raddr;
    logic [CH*WW-1:0]  d_rdata = '0;
    logic [CH*WW-1:0]  d_wreg;
    logic [1:0]        d_x, d_y;
    logic [4:0]        d_X, d_Y;

    weight_shift_tile #(
        .CH(CH), .WW(WW), .AW(AW), .KX(2), .KY(2), .OX(3), .OY(2)
    ) u_small (
        .clk(clk), .xrst(xrst), .start(s_start), .bank(s_bank), .stall(s_stall),
        .mem_re(s_re), .mem_raddr(s_raddr), .mem_rdata(s_rdata), .wreg(s_wreg),
        .pass_east(s_east), .pass_south(s_south), .pass_home(s_home),
        .x(s_x), .y(s_y), .X(s_X), .Y(s_Y), .busy(s_busy), .finish(s_finish)
    );

    weight_shift_tile #(
        .CH(CH), .WW(WW), .AW(AW)
    ) u_dflt (
        .clk(clk), .xrst(xrst), .start(d_start), .bank(d_bank), .stall(d_stall),
        .mem_re(d_re), .mem_raddr(d_raddr), .mem_rdata(d_rdata), .wreg(d_wreg),
        .pass_east(d_east), .pass_south(d_south), .pass_home(d_home),
        .x(d_x), .y(d_y), .X(d_X), .Y(d_Y), .busy(d_busy), .finish(d_finish)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Memory contents: address 5 holds i-8 in lane i; others hold addr*7 + i*3 + 1.
    function automatic logic [CH*WW-1:0] mem_word(input int addr);
        logic [CH*WW-1:0] w;
        w = '0;
        for (int i = 0; i < CH; i++) begin
            if (addr == 5) w[i*WW +: WW] = 8'(i - 8);
            else           w[i*WW +: WW] = 8'(addr * 7 + i * 3 + 1);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (s_re) s_rdata <= mem_word(int'(s_raddr));
        if (d_re) d_rdata <= mem_word(int'(d_raddr));
    end

    // Expected {Y, X, y, x} after k unstalled RUN steps of the small tile.
    function automatic logic [4:0] s_idx(input int k);
        int kx, ky, ox, oy;
        kx = k % 2;
        ky = (k / 2) % 2;
        ox = (k / 4) % 3;
        oy = k / 12;
        return {1'(oy), 2'(ox), 1'(ky), 1'(kx)};
    endfunction

    // Expected {home, south, east} for RUN step k of the small tile.
    function automatic logic [2:0] s_strobe(input int k);
        int  kx, ox;
        logic h;
        kx = k % 2;
        ox = (k / 4) % 3;
        h  = (kx == 1) && (ox == 2);
        return {h, (kx == 1) && !h, kx == 0};
    endfunction

    exp_t s_q[$];
    exp_t d_q[$];
    re_t  s_re_q[$];
    re_t  d_re_q[$];
    int   s_h = 0, s_s = 0, s_e = 0, s_k = 0, s_fin_cnt = 0;
    int   d_h = 0, d_s = 0, d_e = 0, d_multi = 0, d_fin_cnt = 0;

    // small-tile monitor
    always @(negedge clk) begin
        if (xrst) begin
            s_h = 0; s_s = 0; s_e = 0; s_k = 0;
        end else begin
            if (s_re) begin
                if (s_re_q.size() == 0) begin
                    check("s_unexpected_mem_re", 1'b1, 1'b0);
                end else begin
                    re_t r;
                    r = s_re_q.pop_front();
                    check("s_mem_re_cycle", cyc, r.t);
                    check("s_mem_raddr", s_raddr, r.addr);
                end
            end
            if (s_east || s_south || s_home) begin
                check("s_strobe", {s_home, s_south, s_east}, s_strobe(s_k));
                check("s_counters", {s_Y, s_X, s_y, s_x}, s_idx(s_k));
                s_h += int'(s_home);
                s_s += int'(s_south);
                s_e += int'(s_east);
                s_k++;
            end
            if (s_stall && s_busy) begin
                check("s_stall_strobes", {s_home, s_south, s_east}, 3'b000);
                check("s_stall_counters", {s_Y, s_X, s_y, s_x}, s_idx(s_k));
            end
            if (s_finish) begin
                s_fin_cnt++;
                if (s_q.size() == 0) begin
                    check("s_unexpected_finish", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = s_q.pop_front();
                    check("s_finish_latency", cyc - e.t0, e.lat);
                    check("s_home_total", s_h, e.home);
                    check("s_south_total", s_s, e.south);
                    check("s_east_total", s_e, e.east);
                    check("s_wreg", s_wreg, e.w);
                    check("s_raddr_hold", s_raddr, e.bank);
                    check("s_done_counters", {s_Y, s_X, s_y, s_x}, 5'd0);
                end
                s_h = 0; s_s = 0; s_e = 0; s_k = 0;
            end
        end
    end

    // default-tile monitor
    always @(negedge clk) begin
        if (xrst) begin
            d_h = 0; d_s = 0; d_e = 0; d_multi = 0;
        end else begin
            if (d_re) begin
                if (d_re_q.size() == 0) begin
                    check("d_unexpected_mem_re", 1'b1, 1'b0);
                end else begin
                    re_t r;
                    r = d_re_q.pop_front();
                    check("d_mem_re_cycle", cyc, r.t);
                    check("d_mem_raddr", d_raddr, r.addr);
                end
            end
            if ($countones({d_home, d_south, d_east}) > 1) d_multi++;
            d_h += int'(d_home);
            d_s += int'(d_south);
            d_e += int'(d_east);
            if (d_finish) begin
                d_fin_cnt++;
                if (d_q.size() == 0) begin
                    check("d_unexpected_finish", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = d_q.pop_front();
                    check("d_finish_latency", cyc - e.t0, e.lat);
                    check("d_home_total", d_h, e.home);
                    check("d_south_total", d_s, e.south);
                    check("d_east_total", d_e, e.east);
                    check("d_multi_hot_cycles", d_multi, 0);
                    check("d_wreg", d_wreg, e.w);
                end
                d_h = 0; d_s = 0; d_e = 0; d_multi = 0;
            end
        end
    end

    function automatic exp_t s_exp(input int b, input int lat, input int t0);
        exp_t e;
        e.bank = b; e.lat = lat; e.home = 4; e.south = 8; e.east = 12;
        e.w = mem_word(b); e.t0 = t0;
        return e;
    endfunction

    // Called at posedge+1; start is high for the current cycle only.
    task automatic go_s(input int b, input int lat);
        re_t r;
        s_q.push_back(s_exp(b, lat, cyc));
        r.addr = b; r.t = cyc + 1;
        s_re_q.push_back(r);
        s_start = 1'b1;
        s_bank  = AW'(b);
        @(posedge clk); #1;
        s_start = 1'b0;
    endtask

    task automatic wait_s_fin(input int target, input int budget);
        int n;
        n = 0;
        while (s_fin_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("s_finish_seen", s_fin_cnt >= target, 1'b1);
    endtask

    task automatic check_reset_s();
        check("rst_wreg", s_wreg, '0);
        check("rst_mem_re", s_re, 1'b0);
        check("rst_mem_raddr", s_raddr, '0);
        check("rst_strobes", {s_home, s_south, s_east}, 3'b000);
        check("rst_counters", {s_Y, s_X, s_y, s_x}, 5'd0);
        check("rst_busy", s_busy, 1'b0);
        check("rst_finish", s_finish, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f;
        xrst    = 1'b1;
        s_start = 1'b0; s_stall = 1'b0; s_bank = '0;
        d_start = 1'b0; d_stall = 1'b0; d_bank = '0;
        repeat (3) @(posedge clk);
        #1 xrst = 1'b0;
        #1 check_reset_s();
        repeat (3) @(posedge clk);
        #1 check("idle_busy_no_start", s_busy, 1'b0);

        // plain sweep from bank 5
        f = s_fin_cnt;
        go_s(5, S_LAT);
        wait_s_fin(f + 1, 60);
        check("wreg_hold_idle", s_wreg, mem_word(5));
        check("busy_after_done", s_busy, 1'b0);

        // five stall cycles starting at RUN cycle 10
        f = s_fin_cnt;
        go_s(3, S_LAT + 5);
        repeat (12) @(posedge clk);
        #1 s_stall = 1'b1;
        repeat (5) @(posedge clk);
        #1 s_stall = 1'b0;
        wait_s_fin(f + 1, 60);

        // reset at RUN cycle 7, then a full fresh sweep
        go_s(5, S_LAT);
        repeat (9) @(posedge clk);
        #1 xrst = 1'b1;
        #1 check_reset_s();
        s_q.delete();
        s_re_q.delete();
        @(posedge clk);
        #1 xrst = 1'b0;
        f = s_fin_cnt;
        go_s(5, S_LAT);
        wait_s_fin(f + 1, 60);

        // start pulsed with another bank while busy must be ignored
        f = s_fin_cnt;
        go_s(5, S_LAT);
        repeat (6) @(posedge clk);
        #1 s_start = 1'b1; s_bank = 4'd9;
        @(posedge clk);
        #1 s_start = 1'b0;
        wait_s_fin(f + 1, 60);
        repeat (2) @(posedge clk);
        #1 check("no_restart_after_ignored_start", s_busy, 1'b0);

        // start held high restarts on the first IDLE cycle after DONE
        begin
            re_t r;
            f = s_fin_cnt;
            s_q.push_back(s_exp(6, S_LAT, cyc));
            s_q.push_back(s_exp(6, S_LAT, cyc + S_LAT + 1));
            r.addr = 6; r.t = cyc + 1;
            s_re_q.push_back(r);
            r.t = cyc + S_LAT + 2;
            s_re_q.push_back(r);
            s_start = 1'b1; s_bank = 4'd6;
            repeat (30) @(posedge clk);
            #1 s_start = 1'b0;
            wait_s_fin(f + 2, 80);
        end

        // default geometry, bank 0
        begin
            exp_t e;
            re_t  r;
            int   n;
            f = d_fin_cnt;
            e.bank = 0; e.lat = D_LAT; e.home = 57; e.south = 1026; e.east = 2166;
            e.w = mem_word(0); e.t0 = cyc;
            d_q.push_back(e);
            r.addr = 0; r.t = cyc + 1;
            d_re_q.push_back(r);
            d_start = 1'b1; d_bank = '0;
            @(posedge clk);
            #1 d_start = 1'b0;
            n = 0;
            while (d_fin_cnt == f && n < 3400) begin
                @(posedge clk); #1;
                n++;
            end
            check("d_finish_seen", d_fin_cnt != f, 1'b1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("s_queue_drained", s_q.size() + s_re_q.size(), 0);
        check("d_queue_drained", d_q.size() + d_re_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
